// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The driver side uses the master modport and the serializer uses the slave modport.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             ce;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic [CNTW-1:0]  bit_idx;

    modport master (
        output ce, in_data, in_valid,
        input  in_ready, sout, sout_valid, busy, done, bit_idx
    );

    modport slave (
        input  ce, in_data, in_valid,
        output in_ready, sout, sout_valid, busy, done, bit_idx
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a ce bit-rate tick and back-to-back frame chaining.
// A new word can be loaded on the same edge that shifts out the last bit of the current frame.
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);
    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] LastIdx = CNTW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;

    assign last_bit     = (state_q == StShift) && bus.ce && (cnt_q == LastIdx);
    assign bus.in_ready = (state_q == StIdle) || last_bit;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (state_q == StShift && bus.ce) begin
            if (cnt_q == LastIdx) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
        end

        // Loading wins over the frame-end transition so chained frames have no idle gap.
        if (accept) begin
            shreg_d = bus.in_data;
            cnt_d   = '0;
            state_d = StShift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bus.sout_valid = (state_q == StShift);
        bus.busy       = (state_q == StShift);
        bus.done       = done_q;
        bus.bit_idx    = (state_q == StShift) ? cnt_q : '0;
        if (state_q == StShift) begin
            bus.sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end else begin
            bus.sout = IDLE_LEVEL;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an LSB-first and an MSB-first instance share stimulus,
// and every accepted word pushes its expected bit sequence into a scoreboard queue.
module tb_piso_serializer;
    typedef struct packed {
        logic       b_lsb;
        logic       b_msb;
        logic [2:0] idx;
        logic       last;
    } exp_bit_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic exp_done;

    exp_bit_t act_q[$];

    piso_serializer_if #(.WIDTH(8)) if_lsb ();
    piso_serializer_if #(.WIDTH(8)) if_msb ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_lsb)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_msb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        exp_bit_t e;
        for (int i = 0; i < 8; i++) begin
            e.b_lsb = w[i];
            e.b_msb = w[7-i];
            e.idx   = 3'(i);
            e.last  = (i == 7);
            act_q.push_back(e);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance the scoreboard on the edge, check outputs.
    task automatic step(input logic v_ce, input logic v_valid, input logic [7:0] v_data,
                        input logic v_rst);
        logic exp_ready;
        logic pop;
        rst             = v_rst;
        if_lsb.ce       = v_ce;
        if_lsb.in_valid = v_valid;
        if_lsb.in_data  = v_data;
        if_msb.ce       = v_ce;
        if_msb.in_valid = v_valid;
        if_msb.in_data  = v_data;
        #1;
        exp_ready = (act_q.size() == 0) || (v_ce && act_q[0].last);
        if (!v_rst) begin
            chk("in_ready_lsb", 32'(if_lsb.in_ready), 32'(exp_ready));
            chk("in_ready_msb", 32'(if_msb.in_ready), 32'(exp_ready));
        end
        @(posedge clk);
        if (v_rst) begin
            act_q.delete();
            exp_done = 1'b0;
        end else begin
            pop      = (act_q.size() > 0) && v_ce;
            exp_done = pop && act_q[0].last;
            if (pop) void'(act_q.pop_front());
            if (v_valid && exp_ready) push_word(v_data);
        end
        #1;
        chk("sout_valid_lsb", 32'(if_lsb.sout_valid), 32'(act_q.size() > 0));
        chk("busy_lsb", 32'(if_lsb.busy), 32'(act_q.size() > 0));
        chk("done_lsb", 32'(if_lsb.done), 32'(exp_done));
        chk("sout_valid_msb", 32'(if_msb.sout_valid), 32'(act_q.size() > 0));
        chk("busy_msb", 32'(if_msb.busy), 32'(act_q.size() > 0));
        chk("done_msb", 32'(if_msb.done), 32'(exp_done));
        if (act_q.size() > 0) begin
            chk("sout_lsb", 32'(if_lsb.sout), 32'(act_q[0].b_lsb));
            chk("sout_msb", 32'(if_msb.sout), 32'(act_q[0].b_msb));
            chk("bit_idx_lsb", 32'(if_lsb.bit_idx), 32'(act_q[0].idx));
            chk("bit_idx_msb", 32'(if_msb.bit_idx), 32'(act_q[0].idx));
        end else begin
            chk("sout_idle_lsb", 32'(if_lsb.sout), 32'd1);
            chk("sout_idle_msb", 32'(if_msb.sout), 32'd1);
            chk("bit_idx_idle_lsb", 32'(if_lsb.bit_idx), 32'd0);
            chk("bit_idx_idle_msb", 32'(if_msb.bit_idx), 32'd0);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        exp_done        = 1'b0;
        rst             = 1'b1;
        if_lsb.ce       = 1'b0;
        if_lsb.in_valid = 1'b0;
        if_lsb.in_data  = '0;
        if_msb.ce       = 1'b0;
        if_msb.in_valid = 1'b0;
        if_msb.in_data  = '0;

        // Reset, then idle.
        step(1'b1, 1'b1, 8'h33, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Single 0xC5 frame at full rate; in_data churns after acceptance.
        step(1'b1, 1'b1, 8'hC5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i * 37), 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Back-to-back 0xC5 then 0x0F with in_valid held.
        step(1'b1, 1'b1, 8'hC5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h0F, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h0F, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Slow tick: ce every 3rd cycle, stray in_valid pulses while busy.
        step(1'b0, 1'b1, 8'h96, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step((i % 3) == 2, (i % 5) == 1, 8'h3C, 1'b0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-frame after bit 3, with in_valid asserted during reset.
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, frame length in bits; SHALL be >= 2.
REQ-002 Parameter: MSB_FIRST, default 0; 0 = bit 0 shifted out first, 1 = bit WIDTH-1 first.
REQ-003 Parameter: IDLE_LEVEL, default 1, level driven on sout when no frame is active.
REQ-004 Derived: CNTW = max(1, ceil(log2(WIDTH))).
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ce  in  1  shift enable (bit-rate tick); one bit advance per edge with ce=1.
REQ-008 in_data  in  WIDTH  parallel word to serialize.
REQ-009 in_valid  in  1  in_data is valid.
REQ-010 in_ready  out  1  block can accept a word this cycle.
REQ-011 sout  out  1  serial data out.
REQ-012 sout_valid  out  1  sout carries a frame bit.
REQ-013 busy  out  1  frame in progress.
REQ-014 done  out  1  one-cycle pulse, frame completed.
REQ-015 bit_idx  out  CNTW  index (0..WIDTH-1) of the bit currently on sout.

Function
REQ-016 Two states: IDLE and SHIFT; busy = sout_valid = (state == SHIFT).
REQ-017 Word accepted on a rising edge with in_valid=1 and in_ready=1; ce does not gate acceptance.
REQ-018 On acceptance: shift register <= in_data, bit counter <= 0, state <= SHIFT.
REQ-019 in_ready is combinational: 1 in IDLE; 1 in SHIFT only when ce=1 and counter = WIDTH-1; else 0.
REQ-020 in_valid while in_ready=0 is ignored; in_data is not sampled; no state change.
REQ-021 In SHIFT, sout = shift register bit 0 (MSB_FIRST=0) or bit WIDTH-1 (MSB_FIRST=1); in IDLE, sout = IDLE_LEVEL.
REQ-022 First bit appears on sout in the cycle after acceptance (latency 1 clock).
REQ-023 SHIFT, ce=1, counter < WIDTH-1: shift one place toward the output end, fill vacated end with 0, counter += 1.
REQ-024 SHIFT, ce=0: shift register, counter, and state hold; sout is stable.
REQ-025 SHIFT, ce=1, counter = WIDTH-1 (last bit): frame ends on this edge.
REQ-026 At frame end with in_valid=1: new word loaded per REQ-018 on the same edge; state stays SHIFT; no idle gap between frames.
REQ-027 At frame end with in_valid=0: state <= IDLE.
REQ-028 done is registered and set at every frame-end edge, so it is high exactly one cycle after that edge; otherwise 0.
REQ-029 bit_idx = counter in SHIFT; bit_idx = 0 in IDLE.
REQ-030 in_data changing after acceptance has no effect on the frame in progress.

Reset
REQ-031 rst=1 at an edge forces: state IDLE, shift register 0, counter 0, done 0; this overrides acceptance, shifting, and ce.
REQ-032 During and after reset: sout = IDLE_LEVEL, sout_valid = 0, busy = 0, bit_idx = 0, in_ready = 1 (once rst is low).
REQ-033 Reset mid-frame aborts the frame with no done pulse; the next accepted word starts a fresh frame at bit 0.

Verification
REQ-034 Bench: WIDTH=8, MSB_FIRST=0, ce=1, accept 0xC5 -> sout 1,0,1,0,0,0,1,1 on cycles 1..8; bit_idx 0..7; done=1 on cycle 9 only; busy=0 on cycle 9.
REQ-035 Bench: MSB_FIRST=1, accept 0xC5 -> sout 1,1,0,0,0,1,0,1; sout=1 (IDLE_LEVEL) before and after the frame.
REQ-036 Bench: hold in_valid with 0xC5 then 0x0F -> 16 consecutive valid bits with no gap; in_ready=1 only in the last-bit cycle of frame 1; done pulses after each frame.
REQ-037 Bench: ce high every 3rd cycle -> each bit held exactly 3 cycles; in_valid pulses while busy are ignored, and the frame content is unchanged.
REQ-038 Bench: rst asserted after bit 3 of a frame -> next cycle sout_valid=0, sout=IDLE_LEVEL, no done pulse; a following 0xA5 frame serializes correctly from bit 0.
